// File: rtl/uart_pkg.sv
// Shared FSM encoding and frame constants for uart_fifo_tx.
// Macro UART_FIFO_TX_PARITY_EN adds the PARITY state to the encoding.
package uart_pkg;

   localparam int unsigned DATA_BITS  = 8;
   localparam logic        IDLE_LEVEL = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_LOAD   = 3'd2,
      ST_START  = 3'd3,
      ST_DATA   = 3'd4,
`ifdef UART_FIFO_TX_PARITY_EN
      ST_PARITY = 3'd5,
`endif
      ST_STOP   = 3'd6
   } state_t;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, wraps on its own tick,
// and restarts from zero whenever the owner signals a state change.
module uart_baud_cnt #(
   parameter int unsigned CLKS_PER_BIT = 217
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick
);

   localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

   logic [15:0] cnt;

   assign tick = (cnt == LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clear || tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 16'd1;
      end
   end

endmodule

// File: rtl/uart_fifo_tx.sv
// UART transmitter draining an upstream byte FIFO, 8N1 frames.
// Define UART_FIFO_TX_PARITY_EN for 8E1 frames (even parity bit after data).
module uart_fifo_tx
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 217
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       fifo_empty,
   input  logic [7:0] fifo_data,
   output logic       fifo_rd_en,
   output logic       tx,
   output logic       busy,
   output logic [7:0] bytes_sent
);

   state_t                 state;
   state_t                 state_nxt;
   logic [DATA_BITS-1:0]   shreg;
   logic [2:0]             bit_idx;
   logic                   tick;
   logic                   clear;
   logic                   tx_nxt;
`ifdef UART_FIFO_TX_PARITY_EN
   logic                   parity;
`endif

   uart_baud_cnt #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk   (clk),
      .rst   (rst),
      .clear (clear),
      .tick  (tick)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // tx_nxt is the line level for the current state; registering it delays
   // every symbol by one cycle, giving the three-edge start latency.
   always_comb begin
      state_nxt = state;
      tx_nxt    = IDLE_LEVEL;
      case (state)
         ST_IDLE: begin
            if (!fifo_empty) state_nxt = ST_FETCH;
         end
         ST_FETCH: begin
            state_nxt = ST_LOAD;
         end
         ST_LOAD: begin
            state_nxt = ST_START;
         end
         ST_START: begin
            tx_nxt = 1'b0;
            if (tick) state_nxt = ST_DATA;
         end
         ST_DATA: begin
            tx_nxt = shreg[0];
            if (tick && (bit_idx == 3'(DATA_BITS - 1))) begin
`ifdef UART_FIFO_TX_PARITY_EN
               state_nxt = ST_PARITY;
`else
               state_nxt = ST_STOP;
`endif
            end
         end
`ifdef UART_FIFO_TX_PARITY_EN
         ST_PARITY: begin
            tx_nxt = parity;
            if (tick) state_nxt = ST_STOP;
         end
`endif
         ST_STOP: begin
            if (tick) state_nxt = fifo_empty ? ST_IDLE : ST_FETCH;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   assign clear      = (state_nxt != state);
   assign fifo_rd_en = (state == ST_FETCH);
   assign busy       = (state != ST_IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx         <= IDLE_LEVEL;
         shreg      <= '0;
         bit_idx    <= '0;
         bytes_sent <= '0;
`ifdef UART_FIFO_TX_PARITY_EN
         parity     <= 1'b0;
`endif
      end else begin
         tx <= tx_nxt;
         case (state)
            ST_LOAD: begin
               shreg   <= fifo_data;
               bit_idx <= '0;
`ifdef UART_FIFO_TX_PARITY_EN
               parity  <= ^fifo_data;
`endif
            end
            ST_DATA: begin
               if (tick) begin
                  shreg   <= {1'b0, shreg[DATA_BITS-1:1]};
                  bit_idx <= bit_idx + 3'd1;
               end
            end
            ST_STOP: begin
               if (tick) bytes_sent <= bytes_sent + 8'd1;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_fifo_tx.sv
// Scoreboard bench for uart_fifo_tx at CLKS_PER_BIT=4: stimulus queues expected
// bytes, a serial-line monitor decodes frames off tx and compares them.
`timescale 1ns/1ps
module tb_uart_fifo_tx;

   localparam int unsigned CPB = 4;
`ifdef UART_FIFO_TX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   localparam int FRAME = NBITS * CPB;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       fifo_empty;
   logic [7:0] fifo_data = '0;
   logic       fifo_rd_en;
   logic       tx;
   logic       busy;
   logic [7:0] bytes_sent;

   logic [7:0] mem [0:1023];
   int         wr_ptr = 0;
   int         rd_ptr = 0;
   int         cyc = 0;
   int         rd_count = 0;
   int         compared = 0;
   int         mismatched = 0;
   logic [7:0] exp_q[$];
   int         starts[$];

   logic [NBITS-1:0] mon_bits;
   bit               mon_stable;
   bit               mon_abort;
   logic [7:0]       mon_exp;

   assign fifo_empty = (wr_ptr == rd_ptr);

   uart_fifo_tx #(
      .CLKS_PER_BIT(CPB)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .fifo_empty (fifo_empty),
      .fifo_data  (fifo_data),
      .fifo_rd_en (fifo_rd_en),
      .tx         (tx),
      .busy       (busy),
      .bytes_sent (bytes_sent)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (fifo_rd_en) begin
         fifo_data <= mem[rd_ptr];
         rd_ptr    <= rd_ptr + 1;
         rd_count  <= rd_count + 1;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input logic [7:0] b, input bit expect_it);
      mem[wr_ptr] = b;
      wr_ptr++;
      if (expect_it) exp_q.push_back(b);
   endtask

   task automatic wait_tx_low(input int budget, output int at);
      at = -1;
      for (int n = 0; n < budget; n++) begin
         @(negedge clk);
         if (tx === 1'b0) begin
            at = cyc;
            break;
         end
      end
      check("tx_fall_seen", 32'(at >= 0), 1);
   endtask

   task automatic wait_idle(input int budget);
      bit seen = 0;
      for (int n = 0; n < budget; n++) begin
         @(negedge clk);
         if (busy === 1'b0) begin
            seen = 1;
            break;
         end
      end
      check("idle_reached", 32'(seen), 1);
      repeat (8) @(negedge clk);
   endtask

   task automatic wait_bytes(input logic [7:0] v, input int budget);
      bit seen = 0;
      for (int n = 0; n < budget; n++) begin
         @(negedge clk);
         if (bytes_sent === v) begin
            seen = 1;
            break;
         end
      end
      check("bytes_sent_reaches", 32'(bytes_sent), 32'(v));
      check("bytes_sent_in_time", 32'(seen), 1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // Serial-line monitor: samples every cycle of each bit on the falling clock.
   initial begin : monitor
      forever begin
         @(negedge clk);
         if (!rst && tx === 1'b0) begin
            starts.push_back(cyc);
            mon_stable = 1;
            mon_abort  = 0;
            for (int b = 0; b < NBITS && !mon_abort; b++) begin
               for (int s = 0; s < int'(CPB) && !mon_abort; s++) begin
                  if (b != 0 || s != 0) @(negedge clk);
                  if (rst) mon_abort = 1;
                  else if (s == 0) mon_bits[b] = tx;
                  else if (tx !== mon_bits[b]) mon_stable = 0;
               end
            end
            if (!mon_abort) begin
               check("frame_expected", 32'(exp_q.size() > 0), 1);
               if (exp_q.size() > 0) begin
                  mon_exp = exp_q.pop_front();
                  check("start_bit", 32'(mon_bits[0]), 0);
                  check("data_byte", 32'(mon_bits[8:1]), 32'(mon_exp));
`ifdef UART_FIFO_TX_PARITY_EN
                  check("parity_bit", 32'(mon_bits[9]), 32'(^mon_exp));
`endif
                  check("stop_bit", 32'(mon_bits[NBITS-1]), 1);
                  check("bit_stable", 32'(mon_stable), 1);
               end
            end
         end
      end
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      int  c0, at, r0, r1, n0;
      bit  tx_dropped, busy_seen;

      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_tx", 32'(tx), 1);
      check("reset_busy", 32'(busy), 0);
      check("reset_bytes", 32'(bytes_sent), 0);
      check("reset_rd_en", 32'(fifo_rd_en), 0);

      // Empty FIFO: line must stay idle
      rst = 1'b0;
      r0 = rd_count;
      tx_dropped = 0;
      busy_seen  = 0;
      repeat (100) begin
         @(negedge clk);
         if (tx !== 1'b1) tx_dropped = 1;
         if (busy !== 1'b0) busy_seen = 1;
      end
      check("idle_rd_pulses", 32'(rd_count - r0), 0);
      check("idle_tx_high", 32'(tx_dropped), 0);
      check("idle_busy", 32'(busy_seen), 0);
      check("idle_bytes", 32'(bytes_sent), 0);

      // Single byte 0xA5
      r0 = rd_count;
      c0 = cyc;
      push(8'hA5, 1);
      wait_tx_low(20, at);
      check("start_latency", 32'(at - c0), 4);
      wait_idle(200);
      check("a5_bytes_sent", 32'(bytes_sent), 1);
      check("a5_rd_pulses", 32'(rd_count - r0), 1);

      // Three back-to-back bytes
      do_reset();
      r0 = rd_count;
      n0 = starts.size();
      push(8'h01, 1);
      push(8'h80, 1);
      push(8'hFF, 1);
      wait_idle(600);
      check("b2b_frames", 32'(starts.size() - n0), 3);
      if (starts.size() - n0 >= 3) begin
         check("b2b_gap_1", 32'(starts[n0+1] - starts[n0]), 32'(FRAME + 2));
         check("b2b_gap_2", 32'(starts[n0+2] - starts[n0+1]), 32'(FRAME + 2));
      end
      check("b2b_rd_pulses", 32'(rd_count - r0), 3);
      check("b2b_bytes_sent", 32'(bytes_sent), 3);

`ifdef UART_FIFO_TX_PARITY_EN
      // Parity frames: 0x03 even count -> 0, 0x07 odd count -> 1
      do_reset();
      n0 = starts.size();
      push(8'h03, 1);
      push(8'h07, 1);
      wait_idle(400);
      check("par_frames", 32'(starts.size() - n0), 2);
      if (starts.size() - n0 >= 2)
         check("par_spacing", 32'(starts[n0+1] - starts[n0]), 32'(FRAME + 2));
      check("par_bytes_sent", 32'(bytes_sent), 2);
`endif

      // Reset in the middle of the data bits of 0x3C
      do_reset();
      r0 = rd_count;
      push(8'h3C, 0);
      wait_tx_low(20, at);
      repeat (12) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("midrst_tx", 32'(tx), 1);
      check("midrst_busy", 32'(busy), 0);
      check("midrst_bytes", 32'(bytes_sent), 0);
      check("midrst_rd_en", 32'(fifo_rd_en), 0);
      @(negedge clk);
      @(negedge clk);
      push(8'h5A, 1);
      r1 = rd_count;
      rst = 1'b0;
      c0 = cyc;
      wait_tx_low(20, at);
      check("midrst_restart_latency", 32'(at - c0), 4);
      wait_idle(200);
      check("midrst_bytes_after", 32'(bytes_sent), 1);
      check("midrst_rd_new", 32'(rd_count - r1), 1);
      check("midrst_rd_total", 32'(rd_count - r0), 2);

      // 256 frames: counter wraps
      do_reset();
      r0 = rd_count;
      for (int i = 0; i < 256; i++) push(8'(i), 1);
      wait_bytes(8'd255, 256 * (FRAME + 2) + 100);
      wait_bytes(8'd0, 200);
      wait_idle(200);
      check("wrap_rd_pulses", 32'(rd_count - r0), 256);
      check("wrap_queue_drained", 32'(exp_q.size()), 0);
      check("wrap_bytes_final", 32'(bytes_sent), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/uart_fifo_tx.md
UART_FIFO_TX -- requirements
Module: uart_fifo_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 217, clock cycles per serial bit (legal range 2..65535).
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port fifo_empty, input, 1, empty flag of the upstream byte FIFO.
REQ-005 SHALL have port fifo_data, input, 8, FIFO read data, valid the cycle after a read strobe.
REQ-006 SHALL have port fifo_rd_en, output, 1, one-cycle FIFO read strobe.
REQ-007 SHALL have port tx, output, 1, serial line, idle high.
REQ-008 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-009 SHALL have port bytes_sent, output, 8, count of completed frames, wraps 255->0.

Function
REQ-010 SHALL implement FSM states IDLE, FETCH, LOAD, START, DATA, PARITY, STOP.
REQ-011 IDLE: SHALL go to FETCH when fifo_empty=0, else stay in IDLE; tx=1.
REQ-012 FETCH: SHALL assert fifo_rd_en=1 for exactly this one cycle; next state LOAD; tx=1.
REQ-013 LOAD: SHALL capture fifo_data into an 8-bit shift register; next state START; tx=1.
REQ-014 fifo_rd_en SHALL be 0 in every state except FETCH; exactly one strobe per frame.
REQ-015 START: tx=0 for CLKS_PER_BIT cycles, then DATA.
REQ-016 DATA: SHALL send 8 bits LSB first, each held CLKS_PER_BIT cycles; 3-bit index 0..7; after bit 7 goes to PARITY if enabled, else STOP.
REQ-017 STOP: tx=1 for CLKS_PER_BIT cycles; on last cycle SHALL increment bytes_sent and go to FETCH if fifo_empty=0, else IDLE.
REQ-018 Latency: fifo_empty seen low in IDLE at edge k -> tx falls at edge k+3.
REQ-019 Back-to-back frames SHALL have exactly 2 extra idle-high cycles (FETCH, LOAD) between end of stop bit and next start bit.
REQ-020 Bit-period counter SHALL be 16 bits, counting 0..CLKS_PER_BIT-1, cleared on every state change.
REQ-021 fifo_empty changes during a frame SHALL have no effect until STOP's last cycle or IDLE.
REQ-022 tx SHALL be registered (glitch-free).

Reset
REQ-023 rst=1 SHALL immediately, without clock, force state=IDLE, tx=1, fifo_rd_en=0, busy=0, bytes_sent=0, counters=0, shift register=0.
REQ-024 Reset mid-frame SHALL abandon the frame, not count it, and not issue any further fifo_rd_en for it.
REQ-025 After rst deasserts, first FETCH SHALL occur no earlier than the first edge with rst=0.

Configuration
REQ-026 Macro UART_FIFO_TX_PARITY_EN defined: SHALL insert PARITY state after DATA, tx = XOR of the 8 data bits (even parity) for CLKS_PER_BIT cycles; frame = 11 bits.
REQ-027 Macro undefined: PARITY state and parity logic SHALL not exist; DATA goes directly to STOP; frame = 10 bits.

Structure
REQ-028 Package uart_pkg SHALL hold the FSM state encoding (3-bit) and constants DATA_BITS=8, IDLE_LEVEL=1'b1.
REQ-029 Sub-module uart_baud_cnt SHALL contain the bit-period counter (inputs clk, rst, clear; output last-cycle tick); uart_fifo_tx instantiates it once.

Verification (bench uses CLKS_PER_BIT=4)
REQ-030 Reset then fifo_empty=1 for 100 cycles -> tx=1, fifo_rd_en never 1, busy=0, bytes_sent=0.
REQ-031 One byte 0xA5, no parity -> one rd_en pulse; tx = 0,1,0,1,0,0,1,0,1,1, each 4 cycles; start edge 3 cycles after empty falls; bytes_sent=1.
REQ-032 Three bytes 0x01,0x80,0xFF queued -> three frames, each separated by exactly 2 extra high cycles; three rd_en pulses; bytes_sent=3.
REQ-033 With UART_FIFO_TX_PARITY_EN, bytes 0x03 and 0x07 -> parity bit 0 then 1; frames 44 cycles each.
REQ-034 rst asserted mid-DATA of byte 0x3C -> tx=1 same cycle, busy=0, bytes_sent unchanged at 0; after release with empty=0, new frame starts 3 cycles later.
REQ-035 256 frames sent -> bytes_sent wraps to 0.
